// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO between the APB DATA_WT write path and the UART tx serialiser.
// First-word fall-through output, with a level counter, a sticky overflow flag and a low-watermark irq.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 8
) (
  input  logic          pclk,
  input  logic          prst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          flush,
  input  logic          ovf_clr,
  input  logic [AW:0]   thresh,
  input  logic          irq_en,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          irq
);

  localparam logic [AW:0]   LP_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LP_LV1   = (AW+1)'(1);
  localparam logic [AW-1:0] LP_PTR1  = AW'(1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          r_overflow;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_refuse;
  logic w_pop;

  always_comb begin
    w_full   = (r_level == LP_DEPTH);
    w_empty  = (r_level == '0);
    w_push   = wr_en && !w_full;
    w_refuse = wr_en && w_full;
    w_pop    = !w_empty && out_ready;
  end

  // Storage is not reset; out_valid masks stale entries.
  always_ff @(posedge pclk) begin
    if (!prst && !flush && w_push)
      r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      // A refused push outranks a coincident clear; flush never touches the flag.
      if (w_refuse)
        r_overflow <= 1'b1;
      else if (ovf_clr)
        r_overflow <= 1'b0;

      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_push)
          r_wr_ptr <= r_wr_ptr + LP_PTR1;
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + LP_PTR1;
        if (w_push && !w_pop)
          r_level <= r_level + LP_LV1;
        else if (w_pop && !w_push)
          r_level <= r_level - LP_LV1;
      end
    end
  end

  always_comb begin
    out_valid = !w_empty;
    out_data  = r_mem[r_rd_ptr];
    full      = w_full;
    empty     = w_empty;
    level     = r_level;
    overflow  = r_overflow;
    irq       = irq_en && (r_level <= thresh);
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: ordering, full/overflow, wrap, flush priority,
// watermark irq and reset mid-operation, with hand-computed expectations.
module tb_uart_tx_fifo;

  logic       pclk;
  logic       prst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       ovf_clr;
  logic [4:0] thresh;
  logic       irq_en;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;
  logic       irq;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(.DEPTH(16), .AW(4), .DW(8)) dut (
    .pclk      (pclk),
    .prst      (prst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .flush     (flush),
    .ovf_clr   (ovf_clr),
    .thresh    (thresh),
    .irq_en    (irq_en),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow),
    .irq       (irq)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    prst = 1'b1; wr_en = 1'b0; wr_data = '0; flush = 1'b0; ovf_clr = 1'b0;
    thresh = 5'd0; irq_en = 1'b1; out_ready = 1'b0;

    // Reset then idle
    tick(); tick();
    prst = 1'b0;
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_irq", irq, 1);

    // Ordering with a stalled consumer
    wr_en = 1'b1;
    wr_data = 8'h11; tick();
    chk("lat_valid", out_valid, 1);
    wr_data = 8'h22; tick();
    wr_data = 8'h33; tick();
    wr_en = 1'b0;
    chk("ord_level", level, 3);
    chk("ord_head", out_data, 8'h11);
    tick(); tick();
    chk("stall_head", out_data, 8'h11);
    chk("stall_level", level, 3);
    out_ready = 1'b1;
    chk("pop0", out_data, 8'h11); tick();
    chk("pop1", out_data, 8'h22); tick();
    chk("pop2", out_data, 8'h33); tick();
    out_ready = 1'b0;
    chk("ord_empty", empty, 1);
    chk("ord_level0", level, 0);

    // Fill to full, refused push with simultaneous pop
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'(i);
      tick();
    end
    wr_en = 1'b0;
    chk("full_flag", full, 1);
    chk("full_level", level, 16);
    chk("full_irq", irq, 0);
    wr_en = 1'b1; wr_data = 8'hAA; out_ready = 1'b1;
    tick();
    wr_en = 1'b0; out_ready = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_level", level, 15);
    chk("ovf_head", out_data, 8'h01);
    chk("ovf_notfull", full, 0);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_clr", overflow, 0);

    // Refused push and clear on the same edge: set wins
    wr_en = 1'b1; wr_data = 8'hBB; tick();
    chk("refill_full", full, 1);
    wr_data = 8'hCC; ovf_clr = 1'b1; tick();
    wr_en = 1'b0; ovf_clr = 1'b0;
    chk("ovf_setwins", overflow, 1);
    chk("ovf_setwins_lvl", level, 16);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_clr2", overflow, 0);

    // Drain: 0x01..0x0F then 0xBB; 0xAA and 0xCC never stored
    out_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("drain%0d", i), out_data, 32'(i));
      tick();
    end
    chk("drain_bb", out_data, 8'hBB);
    tick();
    out_ready = 1'b0;
    chk("drain_empty", empty, 1);

    // Wrap-around with simultaneous push/pop
    wr_en = 1'b1; wr_data = 8'h40; tick();
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wr_data = 8'(8'h41 + i);
      chk($sformatf("wrap_data%0d", i), out_data, 32'(8'h40 + i));
      tick();
      chk($sformatf("wrap_lvl%0d", i), level, 1);
    end
    wr_en = 1'b0;
    chk("wrap_last", out_data, 8'h68);
    tick();
    out_ready = 1'b0;
    chk("wrap_empty", empty, 1);

    // Flush priority, with overflow held set beforehand
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'(8'h80 + i);
      tick();
    end
    wr_data = 8'hDD; tick();
    wr_en = 1'b0;
    chk("fl_ovf_pre", overflow, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    out_ready = 1'b0;
    chk("fl_level5", level, 5);
    chk("fl_head", out_data, 8'h8B);
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'hEE; out_ready = 1'b1;
    tick();
    flush = 1'b0; wr_en = 1'b0; out_ready = 1'b0;
    chk("fl_level", level, 0);
    chk("fl_empty", empty, 1);
    chk("fl_valid", out_valid, 0);
    chk("fl_ovf", overflow, 1);
    wr_en = 1'b1; wr_data = 8'h55; tick(); wr_en = 1'b0;
    chk("fl_after_head", out_data, 8'h55);
    chk("fl_after_lvl", level, 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("fl_empty2", empty, 1);

    // Watermark
    thresh = 5'd4; irq_en = 1'b1;
    #1;
    chk("wm_irq0", irq, 1);
    wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 8'(8'hA0 + i);
      tick();
    end
    chk("wm_irq_l4", irq, 1);
    wr_data = 8'hA4; tick();
    chk("wm_irq_l5", irq, 0);
    wr_data = 8'hA5; tick();
    wr_en = 1'b0;
    chk("wm_level6", level, 6);
    chk("wm_irq_l6", irq, 0);
    out_ready = 1'b1;
    tick();
    chk("wm_irq_pop1", irq, 0);
    tick();
    out_ready = 1'b0;
    chk("wm_level4", level, 4);
    chk("wm_irq_pop2", irq, 1);
    irq_en = 1'b0; #1;
    chk("wm_irq_dis", irq, 0);
    irq_en = 1'b1; thresh = 5'd16; #1;
    chk("wm_irq_t16", irq, 1);
    thresh = 5'd0; #1;
    chk("wm_irq_t0", irq, 0);

    // Reset mid-operation voids a concurrent handshake
    prst = 1'b1; out_ready = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
    tick();
    prst = 1'b0; out_ready = 1'b0; wr_en = 1'b0;
    chk("mid_rst_level", level, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_irq", irq, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit-side byte buffer between the APB register file (DATA_WT write path) and the UART tx serialiser.
- APB byte writes are queued here. Bytes are presented to the tx engine over a valid/ready handshake, so software can burst-write without polling send state.
- Provides a fill level, full/empty flags, a sticky overflow error and a low-watermark interrupt for the uart_irq tree.
- Sits entirely in the pclk domain. Crossing into the uart clock domain stays downstream.

Parameters:
DEPTH, 16, number of byte entries; power of two, minimum 2
AW, 4, pointer width = log2(DEPTH)
DW, 8, data width per entry

Ports:
pclk  input  1  block clock (APB clock)
prst  input  1  synchronous reset, active-high
wr_en  input  1  push strobe from APB write decode, one byte per cycle
wr_data  input  DW  byte to push
flush  input  1  one-cycle strobe: discard all queued bytes
ovf_clr  input  1  one-cycle strobe: clear sticky overflow
thresh  input  AW+1  low-watermark level
irq_en  input  1  interrupt enable
out_valid  output  1  head entry available to tx engine
out_data  output  DW  head entry
out_ready  input  1  tx engine accepts head entry
full  output  1  level == DEPTH
empty  output  1  level == 0
level  output  AW+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a push was attempted while full
irq  output  1  low-watermark interrupt, level-sensitive

Behaviour:
- Clock and reset: single clock pclk. Reset prst is synchronous and active-high; it is sampled only on the rising edge of pclk.
- Reset values: wr_ptr = rd_ptr = 0, level = 0, overflow = 0. Hence empty = 1, full = 0, out_valid = 0. out_data is don't-care while out_valid = 0. irq = irq_en && (0 <= thresh), i.e. irq = irq_en.
- Storage: DEPTH x DW flop array, written at wr_ptr. Both pointers are AW bits and wrap DEPTH-1 -> 0 naturally. Occupancy is the separate level counter, AW+1 bits.
- Push accepted = wr_en && !full.
  - On accept: mem[wr_ptr] <= wr_data, wr_ptr increments.
- Push refused = wr_en && full.
  - Data is dropped and pointers are unchanged. overflow <= 1 on the same edge.
  - A refused push is not rescued by a simultaneous pop. Full is evaluated before the edge.
- Pop = out_valid && out_ready; rd_ptr increments.
  - out_valid = !empty.
  - out_data = mem[rd_ptr], combinational from the array (first-word fall-through).
- Latency: a byte pushed into an empty FIFO on edge N gives out_valid = 1 after edge N. It can be popped at edge N+1 at the earliest.
- Level update:
  - +1 on accepted push only.
  - -1 on pop only.
  - Unchanged when both occur in the same cycle, or when neither occurs.
- Flags: full = (level == DEPTH), empty = (level == 0). Both are combinational from level.
- Flush has priority over push and pop in the same cycle: pointers <= 0, level <= 0, and the concurrent push is discarded. flush does not change overflow.
- Overflow:
  - Set on a refused push; cleared by ovf_clr.
  - Set wins if a refused push and ovf_clr coincide.
  - Reset clears overflow regardless of other inputs.
- irq = irq_en && (level <= thresh). Combinational, no latching.
  - thresh >= DEPTH gives permanent assertion while enabled.
  - thresh = 0 asserts only when empty.
- Reset mid-operation: all queued data is abandoned. out_valid drops after the reset edge, and a handshake in progress on that edge is void.
- out_data must remain stable while out_valid = 1 and out_ready = 0. The tx engine may stall indefinitely.

Test Plan:
- Reset then idle:
  - prst high 2 cycles, irq_en = 1, thresh = 0 -> level = 0, empty = 1, full = 0, out_valid = 0, overflow = 0, irq = 1.
- Ordering:
  - Push 0x11, 0x22, 0x33 on consecutive cycles with out_ready = 0 -> level = 3, out_data = 0x11.
  - Then out_ready = 1 for 3 cycles -> 0x11, 0x22, 0x33 popped in order, then empty = 1.
- Full/overflow:
  - Push 16 bytes 0x00..0x0F -> full = 1, level = 16.
  - 17th push 0xAA with out_ready = 1 -> 0xAA dropped, overflow = 1, level = 15, out_data = 0x01.
  - ovf_clr -> overflow = 0.
- Wrap-around:
  - Repeat 40 push/pop cycles, pushing and popping simultaneously after one prefill byte -> level stays 1, data stream matches pushed sequence across pointer wrap.
- Flush priority:
  - Level = 5; flush, wr_en and out_ready all high in one cycle -> level = 0, empty = 1, pushed byte never appears.
  - Overflow state is unchanged.
- Watermark:
  - thresh = 4, irq_en = 1. Push 6 bytes -> irq = 0.
  - Pop 2 -> irq = 1 when level = 4.
  - irq_en = 0 -> irq = 0.
